// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 4-to-1 valid/ready channel mux.
// Define MUX4_RR_ARBITER_PKT_LOCK_EN to hold each grant until the beat carrying in_last.
module mux4_rr_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  input  logic [3:0]       in_last,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic [1:0]       sel,
  output logic             busy
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e     state_q;
  logic [1:0] ptr_q;
  logic [1:0] sel_q;

  logic       pick_valid;
  logic [1:0] pick_idx;
  logic [1:0] scan_idx;
  logic       granted;
  logic       xfer;
  logic       grant_release;

  // Scan from the farthest offset down so the nearest requester at or after ptr wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = ptr_q;
    scan_idx   = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      scan_idx = ptr_q + 2'(k);
      if (in_valid[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    out_data = in_data0;
    unique case (sel_q)
      2'd0: out_data = in_data0;
      2'd1: out_data = in_data1;
      2'd2: out_data = in_data2;
      2'd3: out_data = in_data3;
      default: out_data = in_data0;
    endcase
  end

  // Handshake outputs are masked during reset so no beat is accepted in that cycle.
  assign granted   = (state_q == StGrant) && !rst;
  assign out_last  = in_last[sel_q];
  assign out_valid = granted && in_valid[sel_q];
  assign in_ready  = (granted && out_ready) ? (4'b0001 << sel_q) : 4'b0000;
  assign xfer      = out_valid && out_ready;

`ifdef MUX4_RR_ARBITER_PKT_LOCK_EN
  assign grant_release = xfer && in_last[sel_q];
`else
  assign grant_release = xfer;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            sel_q   <= pick_idx;
            state_q <= StGrant;
          end
        end
        StGrant: begin
          if (grant_release) begin
            ptr_q   <= sel_q + 2'd1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sel  = sel_q;
  assign busy = (state_q == StGrant);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed table-driven bench for mux4_rr_arbiter plus hand-written multi-cycle sequences.
module tb_mux4_rr_arbiter;
  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic [3:0]       in_valid;
  logic [3:0]       in_last;
  logic [WIDTH-1:0] in_data0;
  logic [WIDTH-1:0] in_data1;
  logic [WIDTH-1:0] in_data2;
  logic [WIDTH-1:0] in_data3;
  logic [3:0]       in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_ready;
  logic [1:0]       sel;
  logic             busy;

  int n_cmp;
  int n_err;

  mux4_rr_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .in_data3  (in_data3),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic [3:0]       vld;
    logic [3:0]       lst;
    logic             rdy;
    logic             ov;
    logic [3:0]       ir;
    logic [1:0]       sel;
    logic             busy;
    logic [WIDTH-1:0] data;
    logic             olast;
  } vec_t;

  vec_t vec[21];

  // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
  task automatic step(input string nm, input logic r, input logic [3:0] v, input logic [3:0] l,
                      input logic rd, input logic ev, input logic [3:0] eir, input logic [1:0] es,
                      input logic eb, input logic [WIDTH-1:0] ed, input logic el);
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    in_last   = l;
    out_ready = rd;
    #1;
    n_cmp++;
    if ({out_valid, in_ready, sel, busy, out_data, out_last} !== {ev, eir, es, eb, ed, el}) begin
      n_err++;
      $display("FAIL %s: got ov=%b ir=%b sel=%0d busy=%b data=%h last=%b, need ov=%b ir=%b sel=%0d busy=%b data=%h last=%b",
               nm, out_valid, in_ready, sel, busy, out_data, out_last, ev, eir, es, eb, ed, el);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b1;
    in_valid = 4'b1111;
    in_last  = 4'b1111;
    out_ready = 1'b1;
    in_data0 = 8'h10;
    in_data1 = 8'h11;
    in_data2 = 8'h12;
    in_data3 = 8'h13;
    @(posedge clk);

    //          rst   vld      lst      rdy   ov    ir       sel   busy  data   olast
    vec[0]  = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 8'h10, 1'b1};
    vec[1]  = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 8'h10, 1'b1};
    vec[2]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 8'h10, 1'b1};
    vec[3]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 4'h1, 2'd0, 1'b1, 8'h10, 1'b1};
    vec[4]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 8'h10, 1'b1};
    vec[5]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 4'h2, 2'd1, 1'b1, 8'h11, 1'b1};
    vec[6]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 4'h0, 2'd1, 1'b0, 8'h11, 1'b1};
    vec[7]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 4'h4, 2'd2, 1'b1, 8'h12, 1'b1};
    vec[8]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 4'h0, 2'd2, 1'b0, 8'h12, 1'b1};
    vec[9]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 4'h8, 2'd3, 1'b1, 8'h13, 1'b1};
    vec[10] = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 4'h0, 2'd3, 1'b0, 8'h13, 1'b1};
    vec[11] = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 4'h1, 2'd0, 1'b1, 8'h10, 1'b1};
    // ptr=1 now: simultaneous 0 and 2 -> 2 wins; then stall, dropped valid, release.
    vec[12] = '{1'b0, 4'h5, 4'hF, 1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 8'h10, 1'b1};
    vec[13] = '{1'b0, 4'h5, 4'hF, 1'b0, 1'b1, 4'h0, 2'd2, 1'b1, 8'h12, 1'b1};
    vec[14] = '{1'b0, 4'h1, 4'hF, 1'b1, 1'b0, 4'h4, 2'd2, 1'b1, 8'h12, 1'b1};
    vec[15] = '{1'b0, 4'h5, 4'hF, 1'b1, 1'b1, 4'h4, 2'd2, 1'b1, 8'h12, 1'b1};
    // ptr=3: only requester 0 -> wraps to 0.
    vec[16] = '{1'b0, 4'h1, 4'hF, 1'b1, 1'b0, 4'h0, 2'd2, 1'b0, 8'h12, 1'b1};
    vec[17] = '{1'b0, 4'h0, 4'hF, 1'b1, 1'b0, 4'h1, 2'd0, 1'b1, 8'h10, 1'b1};
    vec[18] = '{1'b0, 4'h1, 4'hF, 1'b1, 1'b1, 4'h1, 2'd0, 1'b1, 8'h10, 1'b1};
    vec[19] = '{1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 8'h10, 1'b0};
    vec[20] = '{1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 8'h10, 1'b0};

    for (int i = 0; i < 21; i++) begin
      step($sformatf("vec%0d", i), vec[i].rst, vec[i].vld, vec[i].lst, vec[i].rdy,
           vec[i].ov, vec[i].ir, vec[i].sel, vec[i].busy, vec[i].data, vec[i].olast);
    end

    // Backpressure on requester 1 (ptr=1).
    step("bp_idle", 1'b0, 4'b0010, 4'hF, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 8'h10, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step($sformatf("bp_stall%0d", i), 1'b0, 4'b0010, 4'hF, 1'b0,
           1'b1, 4'h0, 2'd1, 1'b1, 8'h11, 1'b1);
    end
    step("bp_xfer", 1'b0, 4'b0010, 4'hF, 1'b1, 1'b1, 4'h2, 2'd1, 1'b1, 8'h11, 1'b1);
    step("bp_rel", 1'b0, 4'b0000, 4'hF, 1'b1, 1'b0, 4'h0, 2'd1, 1'b0, 8'h11, 1'b1);

    // Requester 2 sends 0xA1..0xA3 while requester 1 also requests (ptr=2).
    in_data2 = 8'hA1;
    step("pk_idle", 1'b0, 4'b0100, 4'h0, 1'b1, 1'b0, 4'h0, 2'd1, 1'b0, 8'h11, 1'b0);
    step("pk_a1", 1'b0, 4'b0110, 4'h0, 1'b1, 1'b1, 4'h4, 2'd2, 1'b1, 8'hA1, 1'b0);
    in_data2 = 8'hA2;
`ifdef MUX4_RR_ARBITER_PKT_LOCK_EN
    step("pk_a2", 1'b0, 4'b0110, 4'h0, 1'b1, 1'b1, 4'h4, 2'd2, 1'b1, 8'hA2, 1'b0);
    in_data2 = 8'hA3;
    step("pk_a3", 1'b0, 4'b0110, 4'b0100, 1'b1, 1'b1, 4'h4, 2'd2, 1'b1, 8'hA3, 1'b1);
    step("pk_gap", 1'b0, 4'b0010, 4'h0, 1'b1, 1'b0, 4'h0, 2'd2, 1'b0, 8'hA3, 1'b0);
    step("pk_req1", 1'b0, 4'b0010, 4'b0010, 1'b1, 1'b1, 4'h2, 2'd1, 1'b1, 8'h11, 1'b1);
    step("pk_end", 1'b0, 4'b0000, 4'h0, 1'b1, 1'b0, 4'h0, 2'd1, 1'b0, 8'h11, 1'b0);
    // ptr=2: requester 3 wins alone; reset lands after beat 2 of its packet.
    step("mr_idle", 1'b0, 4'b1000, 4'h0, 1'b1, 1'b0, 4'h0, 2'd1, 1'b0, 8'h11, 1'b0);
    step("mr_b1", 1'b0, 4'b1000, 4'h0, 1'b1, 1'b1, 4'h8, 2'd3, 1'b1, 8'h13, 1'b0);
    step("mr_b2", 1'b0, 4'b1000, 4'h0, 1'b1, 1'b1, 4'h8, 2'd3, 1'b1, 8'h13, 1'b0);
`else
    step("pk_gap1", 1'b0, 4'b0110, 4'h0, 1'b1, 1'b0, 4'h0, 2'd2, 1'b0, 8'hA2, 1'b0);
    step("pk_req1", 1'b0, 4'b0110, 4'h0, 1'b1, 1'b1, 4'h2, 2'd1, 1'b1, 8'h11, 1'b0);
    step("pk_gap2", 1'b0, 4'b0100, 4'h0, 1'b1, 1'b0, 4'h0, 2'd1, 1'b0, 8'h11, 1'b0);
    step("pk_a2", 1'b0, 4'b0100, 4'h0, 1'b1, 1'b1, 4'h4, 2'd2, 1'b1, 8'hA2, 1'b0);
    step("pk_end", 1'b0, 4'b0000, 4'h0, 1'b1, 1'b0, 4'h0, 2'd2, 1'b0, 8'hA2, 1'b0);
    // ptr=3: requester 3 wins; the second beat's grant is hit by reset.
    step("mr_idle", 1'b0, 4'b1000, 4'h0, 1'b1, 1'b0, 4'h0, 2'd2, 1'b0, 8'hA2, 1'b0);
    step("mr_b1", 1'b0, 4'b1000, 4'h0, 1'b1, 1'b1, 4'h8, 2'd3, 1'b1, 8'h13, 1'b0);
    step("mr_gap", 1'b0, 4'b1000, 4'h0, 1'b1, 1'b0, 4'h0, 2'd3, 1'b0, 8'h13, 1'b0);
`endif
    step("mr_rst", 1'b1, 4'b1111, 4'h0, 1'b1, 1'b0, 4'h0, 2'd3, 1'b1, 8'h13, 1'b0);
    step("mr_after", 1'b0, 4'b1111, 4'h0, 1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 8'h10, 1'b0);
    step("mr_grant0", 1'b0, 4'b1111, 4'h0, 1'b1, 1'b1, 4'h1, 2'd0, 1'b1, 8'h10, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
